fb_swap_ctrl: RTL
=================

Name: fb_swap_ctrl

Overview:
Receiving end of the processor's frame-buffer write/handoff interface.
- Accepts pixel writes (bb_we/waddr/din) into the current back bank of a double-buffered frame memory.
- Accepts the processor's done; on the next vertical-blank start, flips front and back banks.
- Acknowledges the flip on swap with a 4-phase handshake.
- Sits between the processor subsystem, the dual-bank pixel RAM and the video scan-out.

Parameters:
ADDR_W, 17, pixel address width per bank (one bank = 2^ADDR_W words)
FB_DEPTH, 76800, valid pixels per bank; addresses >= FB_DEPTH are dropped
DATA_W, 12, stored pixel width; din low DATA_W bits kept

Ports:
clk_clk  in  1  system clock, all logic on rising edge
reset_reset_n  in  1  asynchronous, active-low reset
bb_we  in  1  back-buffer write strobe, one write per cycle high
waddr  in  32  pixel address within back bank
din  in  32  pixel data
done  in  1  processor finished frame; held high until swap seen
swap  out  1  swap acknowledge to processor
vsync  in  1  active-high vertical sync, synchronous to clk_clk
mem_we  out  1  RAM write enable
mem_waddr  out  ADDR_W+1  {back_bank, waddr[ADDR_W-1:0]}
mem_wdata  out  DATA_W  din[DATA_W-1:0]
front_bank  out  1  bank the scan-out reads

Behaviour:
- Reset (async assert, sync-released logic): state=DRAW, front_bank=0 (back=1), swap=0, mem_we=0, mem_waddr=0, mem_wdata=0, vsync_q=0.
- Write path, registered, latency 1:
  - bb_we=1, waddr<FB_DEPTH, state==DRAW → next cycle mem_we=1 with {~front_bank, waddr[ADDR_W-1:0]}, din[DATA_W-1:0].
  - Otherwise mem_we=0.
  - Out-of-range addresses are dropped silently.
  - Writes in WAIT_VB or ACK are dropped, so the frame is frozen once done is raised.
- vsync edge: vs_rise = vsync & ~vsync_q; vsync_q registered every cycle.
- FSM:
  - DRAW: swap=0; done=1 → WAIT_VB.
  - WAIT_VB: swap=0.
    - done=0 → DRAW (abort, no flip).
    - Else vs_rise → flip front_bank, → ACK.
  - ACK: swap=1; done=0 → DRAW (swap=0 next cycle).
- Simultaneous events:
  - done rise and vs_rise in the same cycle while in DRAW → no flip; the flip waits for the next vs_rise.
  - bb_we in the same cycle done first seen high (DRAW) → write accepted.
  - vs_rise while in ACK → ignored, no second flip.
- front_bank changes only on the WAIT_VB→ACK transition, exactly at a vs_rise cycle (registered, visible the cycle after).
- Reset mid-handshake: returns to DRAW with front_bank=0; the processor must restart with done low.

Optional Feature:
FB_STATS_EN:
- Defined: adds outputs frame_cnt[15:0] (increments on each flip, wraps 0xFFFF→0) and drop_cnt[15:0] (increments per dropped bb_we, saturates at 0xFFFF, clears on flip). Both reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package fb_pkg: FSM enum (DRAW, WAIT_VB, ACK), FB_DEPTH/ADDR_W/DATA_W defaults, bank-select helper.
- One natural sub-module: fb_edge_det, the vsync rising-edge detector, reused by the scan-out.

Test Plan:
- Reset, bb_we=1 waddr=5 din=0xABC → next cycle mem_we=1, mem_waddr={1,5}, mem_wdata=0xABC, front_bank=0.
- waddr=76800 with bb_we=1 → mem_we stays 0 (drop_cnt=1 when FB_STATS_EN).
- done=1, vsync pulse 10 cycles later → front_bank 0→1 the cycle after the edge, swap=1; done=0 → swap=0 next cycle; next write goes to bank 0.
- done=1 then done=0 before any vsync → no flip, swap never rises, writes accepted again.
- done=1 rising in the same cycle as a vsync edge → no flip; flip on the following vsync edge.
- Assert reset_reset_n=0 while in ACK → swap=0 and front_bank=0 immediately; two vsync edges with done held high after release → exactly one flip.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared FSM states, size defaults and bank-select helper for the frame-buffer swap controller.
package fb_pkg;
    typedef enum logic [1:0] {DRAW, WAIT_VB, ACK} fb_state_e;
    localparam int DEF_ADDR_W   = 17;
    localparam int DEF_FB_DEPTH = 76800;
    localparam int DEF_DATA_W   = 12;
    function automatic logic back_bank(input logic front);
        return ~front;
    endfunction
endpackage

// File: rtl/fb_edge_det.sv
// fb_edge_det: single-cycle rising-edge detector for a signal already synchronous to clk_i.
module fb_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);
    logic d_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) d_q <= 1'b0;
        else         d_q <= d_i;
    end
    assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffered frame-memory write path and vblank-aligned bank flip with 4-phase swap ack.
// Define FB_STATS_EN to add frame_cnt/drop_cnt statistics outputs.
module fb_swap_ctrl
    import fb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int FB_DEPTH = DEF_FB_DEPTH,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              bb_we,
    input  logic [31:0]       waddr,
    input  logic [31:0]       din,
    input  logic              done,
    output logic              swap,
    input  logic              vsync,
    output logic              mem_we,
    output logic [ADDR_W:0]   mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              front_bank
`ifdef FB_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
`endif
);
    fb_state_e         state_q, state_d;
    logic              front_q, front_d;
    logic              mem_we_q;
    logic [ADDR_W:0]   mem_waddr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              vs_rise, flip, accept;
    logic              din_unused;

    fb_edge_det u_vs_edge (
        .clk_i  (clk_clk),
        .rst_ni (reset_reset_n),
        .d_i    (vsync),
        .rise_o (vs_rise)
    );

    // Writes are frozen once done is seen, so the handed-off frame cannot change.
    assign accept     = bb_we && state_q == DRAW && waddr < 32'(FB_DEPTH);
    assign din_unused = ^din[31:DATA_W];

    always_comb begin
        state_d = state_q;
        flip    = 1'b0;
        case (state_q)
            DRAW:    if (done) state_d = WAIT_VB;
            WAIT_VB: begin
                if (!done) state_d = DRAW;
                else if (vs_rise) begin
                    state_d = ACK;
                    flip    = 1'b1;
                end
            end
            ACK:     if (!done) state_d = DRAW;
            default: state_d = DRAW;
        endcase
        front_d = front_q ^ flip;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= DRAW;
            front_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            front_q  <= front_d;
            mem_we_q <= accept;
            if (accept) begin
                mem_waddr_q <= {back_bank(front_q), waddr[ADDR_W-1:0]};
                mem_wdata_q <= din[DATA_W-1:0];
            end
        end
    end

    assign swap       = state_q == ACK;
    assign front_bank = front_q;
    assign mem_we     = mem_we_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;

`ifdef FB_STATS_EN
    logic [15:0] frame_cnt_q, drop_cnt_q;
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (flip) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (flip) drop_cnt_q <= '0;
            else if (bb_we && !accept && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif
endmodule
